// File: rtl/systolic_pkg.sv
// Shared definitions for the output-stationary systolic tile: controller states
// and the width helpers used by the top-level parameter defaults.
package systolic_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      FLUSH = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   function automatic int acc_w_default(input int d_w, input int k);
      return 2 * d_w + $clog2(k);
   endfunction

   function automatic int col_w(input int cols);
      return (cols > 1) ? $clog2(cols) : 1;
   endfunction

endpackage

// File: rtl/pe_os_mac.sv
// Output-stationary MAC cell: registers a/b for forwarding right/down and
// accumulates their product in place while the array advances.
module pe_os_mac #(
   parameter int D_W   = 8,
   parameter int ACC_W = 19
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             advance,
   input  logic             signed_mode,
   input  logic [D_W-1:0]   a,
   input  logic [D_W-1:0]   b,
   output logic [D_W-1:0]   a_fwd,
   output logic [D_W-1:0]   b_fwd,
   output logic [ACC_W-1:0] acc
);

   logic [ACC_W-1:0] a_ext;
   logic [ACC_W-1:0] b_ext;
   logic [ACC_W-1:0] prod;

   // Modular product of the extended operands equals the signed product mod 2^ACC_W.
   assign a_ext = signed_mode ? {{(ACC_W-D_W){a[D_W-1]}}, a} : {{(ACC_W-D_W){1'b0}}, a};
   assign b_ext = signed_mode ? {{(ACC_W-D_W){b[D_W-1]}}, b} : {{(ACC_W-D_W){1'b0}}, b};
   assign prod  = a_ext * b_ext;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         a_fwd <= '0;
         b_fwd <= '0;
         acc   <= '0;
      end else if (advance) begin
         a_fwd <= a;
         b_fwd <= b;
         acc   <= acc + prod;
      end
   end

endmodule

// File: rtl/systolic_os_tile.sv
// ROWS x COLS output-stationary systolic tile: skewed operand feed, zero flush,
// then results drained one column per cycle, last column first.
//
// state | meaning
// IDLE  | waiting for start; accumulators hold last tile
// LOAD  | accepting K operand beats (in_ready=1)
// FLUSH | injecting zeros until the last PE has seen beat K-1
// DRAIN | presenting column out_col, COLS-1 down to 0
// DONE  | one-cycle done pulse
module systolic_os_tile import systolic_pkg::*; #(
   parameter int D_W   = 8,
   parameter int ROWS  = 3,
   parameter int COLS  = 3,
   parameter int K     = 6,
   parameter int ACC_W = acc_w_default(D_W, K)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        signed_mode,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [ROWS-1:0][D_W-1:0]    a_in,
   input  logic [COLS-1:0][D_W-1:0]    b_in,
   output logic [ROWS-1:0][ACC_W-1:0]  out_data,
   output logic                        out_valid,
   output logic [col_w(COLS)-1:0]      out_col,
   output logic                        busy,
   output logic                        done
);

   localparam int OCW     = col_w(COLS);
   localparam int FLUSH_N = ROWS + COLS - 2;
   localparam int CM1     = (K - 1 > COLS - 1) ? K - 1 : COLS - 1;
   localparam int CNT_MAX = (FLUSH_N - 1 > CM1) ? FLUSH_N - 1 : CM1;
   localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             mode;
   logic             clear;
   logic             advance;

   logic [ROWS-1:0][D_W-1:0] a_feed;
   logic [COLS-1:0][D_W-1:0] b_feed;

   logic [D_W-1:0]   a_h    [ROWS][COLS+1];
   logic [D_W-1:0]   b_v    [ROWS+1][COLS];
   logic [ACC_W-1:0] acc_h  [ROWS][COLS];

   assign clear   = (state == IDLE) && start;
   assign advance = ((state == LOAD) && in_valid) || (state == FLUSH);
   assign a_feed  = (state == LOAD) ? a_in : '0;
   assign b_feed  = (state == LOAD) ? b_in : '0;

   // One down-counter serves beat, flush and drain phases; each phase reloads it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         mode  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               state <= LOAD;
               cnt   <= CNT_W'(K - 1);
               mode  <= signed_mode;
            end
            LOAD: if (in_valid) begin
               if (cnt == '0) begin
                  if (FLUSH_N == 0) begin
                     state <= DRAIN;
                     cnt   <= CNT_W'(COLS - 1);
                  end else begin
                     state <= FLUSH;
                     cnt   <= CNT_W'(FLUSH_N - 1);
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            FLUSH: begin
               if (cnt == '0) begin
                  state <= DRAIN;
                  cnt   <= CNT_W'(COLS - 1);
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            DRAIN: begin
               if (cnt == '0) state <= DONE;
               else           cnt   <= cnt - CNT_W'(1);
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_row_skew
      if (r == 0) begin : g_direct
         assign a_h[0][0] = a_feed[0];
      end else begin : g_dly
         logic [D_W-1:0] sr [r];
         always_ff @(posedge clk) begin
            if (rst || clear) begin
               for (int i = 0; i < r; i++) sr[i] <= '0;
            end else if (advance) begin
               sr[0] <= a_feed[r];
               for (int i = 1; i < r; i++) sr[i] <= sr[i-1];
            end
         end
         assign a_h[r][0] = sr[r-1];
      end
   end

   for (genvar c = 0; c < COLS; c++) begin : g_col_skew
      if (c == 0) begin : g_direct
         assign b_v[0][0] = b_feed[0];
      end else begin : g_dly
         logic [D_W-1:0] sr [c];
         always_ff @(posedge clk) begin
            if (rst || clear) begin
               for (int i = 0; i < c; i++) sr[i] <= '0;
            end else if (advance) begin
               sr[0] <= b_feed[c];
               for (int i = 1; i < c; i++) sr[i] <= sr[i-1];
            end
         end
         assign b_v[0][c] = sr[c-1];
      end
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_pe_row
      for (genvar c = 0; c < COLS; c++) begin : g_pe_col
         pe_os_mac #(.D_W(D_W), .ACC_W(ACC_W)) u_pe (
            .clk         (clk),
            .rst         (rst),
            .clear       (clear),
            .advance     (advance),
            .signed_mode (mode),
            .a           (a_h[r][c]),
            .b           (b_v[r][c]),
            .a_fwd       (a_h[r][c+1]),
            .b_fwd       (b_v[r+1][c]),
            .acc         (acc_h[r][c])
         );
      end
   end

   assign in_ready  = (state == LOAD);
   assign out_valid = (state == DRAIN);
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign out_col   = (state == DRAIN) ? cnt[OCW-1:0] : '0;

   always_comb begin
      out_data = '0;
      if (state == DRAIN) begin
         for (int r = 0; r < ROWS; r++) out_data[r] = acc_h[r][out_col];
      end
   end

endmodule

// File: tb/tb_systolic_os_tile.sv
// Directed bench for systolic_os_tile: a 2x2/K=2/ACC_W=16 instance and a 3x4/K=6 instance.
module tb_systolic_os_tile;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic             s_start, s_mode, s_valid, s_ready, s_ovalid, s_busy, s_done;
   logic [1:0][7:0]  s_a, s_b;
   logic [1:0][15:0] s_data;
   logic [0:0]       s_col;

   logic             r_start, r_mode, r_valid, r_ready, r_ovalid, r_busy, r_done;
   logic [2:0][7:0]  r_a;
   logic [3:0][7:0]  r_b;
   logic [2:0][18:0] r_data;
   logic [1:0]       r_col;

   systolic_os_tile #(.D_W(8), .ROWS(2), .COLS(2), .K(2), .ACC_W(16)) u_small (
      .clk(clk), .rst(rst), .start(s_start), .signed_mode(s_mode),
      .in_valid(s_valid), .in_ready(s_ready), .a_in(s_a), .b_in(s_b),
      .out_data(s_data), .out_valid(s_ovalid), .out_col(s_col),
      .busy(s_busy), .done(s_done)
   );

   systolic_os_tile #(.D_W(8), .ROWS(3), .COLS(4), .K(6)) u_rect (
      .clk(clk), .rst(rst), .start(r_start), .signed_mode(r_mode),
      .in_valid(r_valid), .in_ready(r_ready), .a_in(r_a), .b_in(r_b),
      .out_data(r_data), .out_valid(r_ovalid), .out_col(r_col),
      .busy(r_busy), .done(r_done)
   );

   logic [7:0]  sa [2][2];   // A[r][k]
   logic [7:0]  sb [2][2];   // B[k][c]
   logic [15:0] se [2][2];   // expected C[r][c]
   int          s_gap;
   bit          s_poke;
   bit          s_abort;

   task automatic set_ops(input int a00, a01, a10, a11, b00, b01, b10, b11,
                          input int c00, c01, c10, c11);
      sa[0][0] = 8'(a00); sa[0][1] = 8'(a01); sa[1][0] = 8'(a10); sa[1][1] = 8'(a11);
      sb[0][0] = 8'(b00); sb[0][1] = 8'(b01); sb[1][0] = 8'(b10); sb[1][1] = 8'(b11);
      se[0][0] = 16'(c00); se[0][1] = 16'(c01); se[1][0] = 16'(c10); se[1][1] = 16'(c11);
   endtask

   // Runs one tile on the 2x2 instance; returns at the negedge of the done cycle.
   task automatic run_s(input string name, input logic mode, input int exp_done);
      int beat, stall, drains, done_cyc;
      bit fin;
      @(negedge clk);
      s_start = 1'b1; s_mode = mode; s_valid = 1'b0;
      beat = 0; stall = 0; drains = 0; done_cyc = -1; fin = 1'b0;
      for (int cyc = 1; cyc <= 40 && !fin; cyc++) begin
         @(negedge clk);
         s_start = 1'b0;
         s_mode  = ~mode;
         if (cyc == 1) begin
            n_checks++;
            if (s_busy !== 1'b1) begin
               n_fail++; $display("FAIL %s busy_rise: got %b want 1", name, s_busy);
            end
         end
         if (s_ovalid) begin
            if (drains < 2) begin
               n_checks++;
               if (s_col !== 1'(1 - drains)) begin
                  n_fail++; $display("FAIL %s out_col beat %0d: got %0d want %0d", name, drains, s_col, 1 - drains);
               end
               for (int r = 0; r < 2; r++) begin
                  n_checks++;
                  if (s_data[r] !== se[r][1-drains]) begin
                     n_fail++;
                     $display("FAIL %s out_data[%0d] col %0d: got %0d want %0d", name, r, 1 - drains, s_data[r], se[r][1-drains]);
                  end
               end
            end
            drains++;
            if (s_abort && drains == 2) begin
               rst = 1'b1;
               @(negedge clk);
               n_checks++;
               if ({s_ready, s_ovalid, s_busy, s_done, s_data, s_col} !== '0) begin
                  n_fail++;
                  $display("FAIL %s abort_outputs: got rdy=%b vld=%b busy=%b done=%b data=%h col=%0d want all 0",
                           name, s_ready, s_ovalid, s_busy, s_done, s_data, s_col);
               end
               rst = 1'b0;
               s_valid = 1'b0;
               return;
            end
            if (s_poke && drains == 1) s_start = 1'b1;
         end
         if (s_poke && cyc == 1) s_start = 1'b1;
         if (s_done) begin
            done_cyc = cyc;
            fin = 1'b1;
         end
         s_valid = 1'b0;
         if (s_ready && beat < 2 && !fin) begin
            if (stall > 0) stall--;
            else begin
               s_valid = 1'b1;
               s_a[0] = sa[0][beat]; s_a[1] = sa[1][beat];
               s_b[0] = sb[beat][0]; s_b[1] = sb[beat][1];
               beat++;
               stall = s_gap;
            end
         end
      end
      n_checks++;
      if (drains !== 2) begin
         n_fail++; $display("FAIL %s drain_beats: got %0d want 2", name, drains);
      end
      n_checks++;
      if (done_cyc !== exp_done) begin
         n_fail++; $display("FAIL %s done_cycle: got %0d want %0d", name, done_cyc, exp_done);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({s_ready, s_ovalid, s_busy, s_done, s_data, s_col} !== '0) begin
         n_fail++; $display("FAIL reset_small: got data=%h flags=%b%b%b%b col=%0d want all 0",
                            s_data, s_ready, s_ovalid, s_busy, s_done, s_col);
      end
      n_checks++;
      if ({r_ready, r_ovalid, r_busy, r_done, r_data, r_col} !== '0) begin
         n_fail++; $display("FAIL reset_rect: got data=%h flags=%b%b%b%b col=%0d want all 0",
                            r_data, r_ready, r_ovalid, r_busy, r_done, r_col);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic_2x2();
      s_gap = 0; s_poke = 1'b0; s_abort = 1'b0;
      set_ops(1, 2, 3, 4, 5, 6, 7, 8, 19, 22, 43, 50);
      run_s("basic", 1'b0, 7);
   endtask

   task automatic test_back_to_back();
      set_ops(2, 0, 1, 3, 4, 1, 5, 2, 8, 2, 19, 7);
      run_s("b2b", 1'b0, 7);
   endtask

   task automatic test_stall();
      s_gap = 3;
      set_ops(1, 2, 3, 4, 5, 6, 7, 8, 19, 22, 43, 50);
      run_s("stall", 1'b0, 10);
      s_gap = 0;
   endtask

   task automatic test_wrap();
      set_ops(255, 255, 255, 255, 255, 255, 255, 255, 64514, 64514, 64514, 64514);
      run_s("wrap", 1'b0, 7);
   endtask

   task automatic test_ignored_start();
      s_poke = 1'b1;
      set_ops(1, 2, 3, 4, 5, 6, 7, 8, 19, 22, 43, 50);
      run_s("ignored_start", 1'b0, 7);
      s_poke = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (s_busy !== 1'b0) begin
         n_fail++; $display("FAIL ignored_start idle_after: got busy=%b want 0", s_busy);
      end
   endtask

   task automatic test_abort_reset();
      s_abort = 1'b1;
      set_ops(1, 2, 3, 4, 5, 6, 7, 8, 19, 22, 43, 50);
      run_s("abort", 1'b0, 0);
      s_abort = 1'b0;
      set_ops(10, 1, 0, 7, 3, 9, 2, 4, 32, 94, 14, 28);
      run_s("after_abort", 1'b0, 7);
   endtask

   task automatic test_signed_rect();
      int beat, drains, done_cyc;
      bit fin;
      @(negedge clk);
      r_start = 1'b1; r_mode = 1'b1; r_valid = 1'b0;
      beat = 0; drains = 0; done_cyc = -1; fin = 1'b0;
      for (int cyc = 1; cyc <= 60 && !fin; cyc++) begin
         @(negedge clk);
         r_start = 1'b0;
         r_mode  = 1'b0;
         if (r_ovalid) begin
            if (drains < 4) begin
               n_checks++;
               if (r_col !== 2'(3 - drains)) begin
                  n_fail++; $display("FAIL rect out_col beat %0d: got %0d want %0d", drains, r_col, 3 - drains);
               end
               for (int r = 0; r < 3; r++) begin
                  n_checks++;
                  if (r_data[r] !== 19'h7FFF4) begin
                     n_fail++; $display("FAIL rect out_data[%0d] beat %0d: got %h want 7fff4", r, drains, r_data[r]);
                  end
               end
            end
            drains++;
         end
         if (r_done) begin
            done_cyc = cyc;
            fin = 1'b1;
         end
         r_valid = 1'b0;
         if (r_ready && beat < 6 && !fin) begin
            r_valid = 1'b1;
            r_a = {3{8'hFF}};
            r_b = {4{8'd2}};
            beat++;
         end
      end
      n_checks++;
      if (drains !== 4) begin
         n_fail++; $display("FAIL rect drain_beats: got %0d want 4", drains);
      end
      n_checks++;
      if (done_cyc !== 16) begin
         n_fail++; $display("FAIL rect done_cycle: got %0d want 16", done_cyc);
      end
   endtask

   initial begin
      rst = 1'b1;
      s_start = 1'b0; s_mode = 1'b0; s_valid = 1'b0; s_a = '0; s_b = '0;
      r_start = 1'b0; r_mode = 1'b0; r_valid = 1'b0; r_a = '0; r_b = '0;
      s_gap = 0; s_poke = 1'b0; s_abort = 1'b0;
      test_reset();
      test_basic_2x2();
      test_back_to_back();
      test_signed_rect();
      test_stall();
      test_wrap();
      test_ignored_start();
      test_abort_reset();
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
